// File: rtl/vga_wave_pkg.sv
// Constants shared by the wave phase driver and the drawing modules that consume its offsets.
package vga_wave_pkg;
  localparam int          H_ACTIVE   = 640;
  localparam logic [9:0]  X_STEP_DEF = 10'd40;
  localparam int          POS_W      = 4;
  localparam int          SIN_W      = 8;
endpackage

// File: rtl/frame_divider.sv
// Frame divider: turns frame_tick into a phase step every (speed+1) frames while run is set.
module frame_divider #(
  parameter int SPEED_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               run,
  input  logic [SPEED_W-1:0] speed,
  output logic               step
);

  logic [SPEED_W-1:0] count;

  // >= rather than == so a speed lowered below the running count steps on the next tick
  assign step = frame_tick & run & (count >= speed);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (frame_tick && run) begin
      if (step) count <= '0;
      else      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sine_wave_driver.sv
// Phase driver ahead of sine_lut: steps pos/x_offset on frame ticks and latches the LUT sample
// into y_offset so drawing logic only ever sees offsets that change during vertical blanking.
module sine_wave_driver
  import vga_wave_pkg::*;
#(
  parameter int         SPEED_W = 3,
  parameter logic [9:0] X_STEP  = X_STEP_DEF,
  parameter logic [9:0] X_WRAP  = 10'(H_ACTIVE)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               run,
  input  logic [SPEED_W-1:0] speed,
  input  logic               dir,
  input  logic [SIN_W-1:0]   sin_in,
  output logic [POS_W-1:0]   pos,
  output logic [SIN_W-1:0]   y_offset,
  output logic [9:0]         x_offset,
  output logic               valid,
  output logic               wrap_pulse
);

  logic step;
  logic load;

  frame_divider #(.SPEED_W(SPEED_W)) u_div (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .run        (run),
    .speed      (speed),
    .step       (step)
  );

  // One extra bit holds the overflow/underflow so a single correction brings x back in range
  function automatic logic [9:0] next_x(input logic [9:0] x, input logic down);
    logic [10:0] t;
    if (!down) begin
      t = {1'b0, x} + {1'b0, X_STEP};
      if (t >= {1'b0, X_WRAP}) t = t - {1'b0, X_WRAP};
    end else begin
      t = {1'b0, x} - {1'b0, X_STEP};
      if (t[10]) t = t + {1'b0, X_WRAP};
    end
    return t[9:0];
  endfunction

  function automatic logic [POS_W-1:0] next_pos(input logic [POS_W-1:0] p, input logic down);
    return down ? p - 1'b1 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos        <= '0;
      y_offset   <= '0;
      x_offset   <= '0;
      valid      <= 1'b0;
      wrap_pulse <= 1'b0;
      load       <= 1'b1;
    end else begin
      wrap_pulse <= 1'b0;
      // A step takes priority; the LUT needs a cycle to settle on the new pos before capture
      if (step) begin
        pos        <= next_pos(pos, dir);
        x_offset   <= next_x(x_offset, dir);
        wrap_pulse <= dir ? (pos == '0) : (pos == '1);
        load       <= 1'b1;
        valid      <= 1'b0;
      end else if (load) begin
        y_offset <= sin_in;
        valid    <= 1'b1;
        load     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sine_wave_driver.sv
// Directed bench for sine_wave_driver with a behavioural 16-entry sine table on sin_in.
module tb_sine_wave_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic       run;
  logic [2:0] speed;
  logic       dir;
  logic [7:0] sin_in;
  logic [3:0] pos;
  logic [7:0] y_offset;
  logic [9:0] x_offset;
  logic       valid;
  logic       wrap_pulse;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] lut_val(input logic [3:0] i);
    case (i)
      4'd0:  return 8'd128;  4'd1:  return 8'd177;
      4'd2:  return 8'd218;  4'd3:  return 8'd245;
      4'd4:  return 8'd255;  4'd5:  return 8'd245;
      4'd6:  return 8'd218;  4'd7:  return 8'd177;
      4'd8:  return 8'd128;  4'd9:  return 8'd79;
      4'd10: return 8'd38;   4'd11: return 8'd11;
      4'd12: return 8'd1;    4'd13: return 8'd11;
      4'd14: return 8'd38;   default: return 8'd79;
    endcase
  endfunction

  assign sin_in = lut_val(pos);

  sine_wave_driver dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .run        (run),
    .speed      (speed),
    .dir        (dir),
    .sin_in     (sin_in),
    .pos        (pos),
    .y_offset   (y_offset),
    .x_offset   (x_offset),
    .valid      (valid),
    .wrap_pulse (wrap_pulse)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Pulse frame_tick for one cycle; returns at the negedge after the tick edge
  task automatic do_tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
  endtask

  int wraps;
  int exp_pos;

  initial begin
    rst = 1'b1; frame_tick = 1'b0; run = 1'b0; speed = 3'd0; dir = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pos",   pos, 0);
    check("rst_x",     x_offset, 0);
    check("rst_valid", valid, 0);
    check("rst_y",     y_offset, 0);
    check("rst_wrap",  wrap_pulse, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_valid", valid, 1);
    check("rel_y",     y_offset, 128);

    // speed 0, incrementing: 17 steps through a full wrap
    run = 1'b1; wraps = 0;
    for (int i = 1; i <= 17; i++) begin
      do_tick();
      check("inc_pos",   pos, i % 16);
      check("inc_x",     x_offset, (40 * i) % 640);
      check("inc_vld0",  valid, 0);
      check("inc_wrap",  wrap_pulse, (i == 16) ? 1 : 0);
      if (wrap_pulse) wraps++;
      @(negedge clk);
      check("inc_vld1",  valid, 1);
      check("inc_y",     y_offset, lut_val(4'(i % 16)));
      check("inc_wrap0", wrap_pulse, 0);
    end
    check("inc_wraps", wraps, 1);

    // speed 2: steps on every third tick
    do_reset();
    speed = 3'd2;
    for (int i = 1; i <= 9; i++) begin
      do_tick();
      exp_pos = i / 3;
      check("spd_pos", pos, exp_pos);
      check("spd_vld", valid, (i % 3 == 0) ? 0 : 1);
      @(negedge clk);
    end
    check("spd_pos_end", pos, 3);
    check("spd_x_end",   x_offset, 120);
    check("spd_y_end",   y_offset, 245);

    // decrementing from reset wraps 0 -> 15
    do_reset();
    speed = 3'd0; dir = 1'b1;
    do_tick();
    check("dec_pos",  pos, 15);
    check("dec_x",    x_offset, 600);
    check("dec_wrap", wrap_pulse, 1);
    @(negedge clk);
    check("dec_wrap0", wrap_pulse, 0);
    check("dec_y",     y_offset, 79);
    dir = 1'b0;

    // frozen divider: count held at 2 across ignored ticks
    do_reset();
    speed = 3'd3;
    do_tick(); do_tick();
    check("frz_pre", pos, 0);
    run = 1'b0;
    repeat (5) do_tick();
    check("frz_pos", pos, 0);
    check("frz_x",   x_offset, 0);
    check("frz_y",   y_offset, 128);
    run = 1'b1;
    do_tick();
    check("frz_cnt3", pos, 0);
    do_tick();
    check("frz_step", pos, 1);
    do_tick(); do_tick();
    check("lower_pre", pos, 1);
    speed = 3'd1;
    do_tick();
    check("lower_step", pos, 2);
    check("lower_x",    x_offset, 80);

    // reset between a step and its capture
    speed = 3'd0;
    do_tick();
    check("mid_vld0", valid, 0);
    check("mid_pos",  pos, 3);
    rst = 1'b1;
    #1;
    check("mid_rst_pos", pos, 0);
    check("mid_rst_x",   x_offset, 0);
    check("mid_rst_vld", valid, 0);
    check("mid_rst_y",   y_offset, 0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check("mid_rel_vld", valid, 1);
    check("mid_rel_y",   y_offset, 128);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sine_wave_driver.md
# sine_wave_driver

Sequential phase stage that sits directly upstream of `sine_lut`. It advances the 4-bit `pos` index once every N frames, registers the LUT's `sin_output` into a stable per-frame `y_offset`, and maintains a matching horizontal scroll `x_offset` for `double_sin`. Drawing modules see offsets that change only during vertical blanking, never mid-frame.

## Interface
Parameters:
- `SPEED_W`, 3: width of the `speed` input and the frame divider counter.
- `X_STEP`, 10'd40: pixels added to `x_offset` per phase step.
- `X_WRAP`, 10'd640: modulus of `x_offset` (active line width).

Ports:
- `clk`  in  1  system clock (pixel clock).
- `rst`  in  1  reset; one clock, asynchronous, active-high.
- `frame_tick`  in  1  single-cycle pulse at the start of vertical blanking.
- `run`  in  1  1 = phase advance enabled; 0 = frozen.
- `speed`  in  SPEED_W  frames per step minus 1; 0 = every frame, 7 = every 8th frame.
- `dir`  in  1  0 = pos increments, 1 = pos decrements.
- `sin_in`  in  8  `sin_output` from `sine_lut`, combinational in `pos`.
- `pos`  out  4  registered phase index driven into `sine_lut.pos`.
- `y_offset`  out  8  registered sample of `sin_in` for the current `pos`.
- `x_offset`  out  10  registered horizontal scroll, always in 0..X_WRAP-1.
- `valid`  out  1  1 = `y_offset` corresponds to current `pos`.
- `wrap_pulse`  out  1  one-cycle pulse when `pos` wraps (15→0 when dir=0, 0→15 when dir=1).

## Operation
- Reset values: `pos`=0, `y_offset`=0, `x_offset`=0, `valid`=0, `wrap_pulse`=0, divider count=0, `load` flag=1.
- Divider: on `frame_tick` with `run`=1: if count >= `speed`, issue a step and clear count; else count+1. Use >= so that lowering `speed` below the current count steps on the next tick. With `run`=0, the count holds and no step is issued. `frame_tick` with `run`=0 is ignored.
- Step, registered on the tick cycle:
  - `pos` ← `pos`±1, mod 16.
  - `x_offset` ← (`x_offset` + X_STEP) mod X_WRAP when dir=0; (`x_offset` − X_STEP) mod X_WRAP when dir=1. Compute with an 11-bit intermediate and a single conditional correction.
  - `wrap_pulse` ← 1 only if `pos` wrapped; otherwise 0 every cycle.
  - `load` ← 1, `valid` ← 0.
- Capture: on any cycle with `load`=1, `y_offset` ← `sin_in`, `valid` ← 1, `load` ← 0. Otherwise `y_offset` holds.
- Simultaneous step and capture: the step wins. `load` stays 1, `y_offset` is captured on the following cycle.
- `dir` and `speed` are sampled only on the tick cycle. Changing them between ticks has no effect until the next tick.
- `rst` asserted mid-operation: all state returns to reset values immediately (asynchronous). Operation resumes on the first clock after deassertion.

## Timing
- Tick at cycle T with a step due:
  - `pos`, `x_offset`, `wrap_pulse` update at the T+1 edge.
  - `valid`=0 during T+1.
  - `y_offset` updates and `valid`=1 at the T+2 edge.
- Two-cycle latency from tick to valid `y_offset`, well inside vertical blanking.
- After reset release: the first clock captures `sin_in` for pos 0, so `valid`=1 one cycle after release.
- `wrap_pulse` width is exactly one cycle. Back-to-back ticks (test only) each step independently.
- No combinational path from any input to any output.

## Structure
- Shared package `vga_wave_pkg`: `H_ACTIVE`=640, default `X_STEP`, `POS_W`=4, `SIN_W`=8. Drawing modules (`double_sin`, `U_shape`) import the same constants.
- One natural sub-module: `frame_divider` (count, `speed` compare, `run` gating → `step` pulse).
- Phase, scroll and capture registers live in `sine_wave_driver`. `sine_lut` is instantiated by the parent, not inside this block.

## Test plan
- Reset release with a real `sine_lut` attached:
  - `pos`=0, `x_offset`=0, `valid`=0 while `rst`=1.
  - One clock after release: `valid`=1, `y_offset`=LUT[0].
- speed=0, dir=0, run=1, 17 ticks:
  - `pos` sequence 1..15,0,1; `x_offset` 40,80,…,600,0,40.
  - `wrap_pulse` high exactly once, on the 15→0 step.
  - `y_offset`=LUT[pos] two cycles after each tick.
- speed=2: 9 ticks → steps on ticks 3, 6, 9 only; `pos`=3, `x_offset`=120.
- dir=1 from reset, speed=0, one tick → `pos`=15, `x_offset`=600, `wrap_pulse`=1 for one cycle.
- run=0 across 5 ticks → outputs and divider count unchanged. With speed=3 and count at 2, lower speed to 1 and tick → immediate step.
- Reset mid-operation: assert `rst` in the cycle between a step and its capture (`valid`=0) → all outputs return to reset values asynchronously. On release, normal capture of LUT[0].
